// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: program counter and fetch sequencer for the combinational instruction ROM.
// The PC register drives the ROM address directly. It steps sequentially, takes absolute
// or relative branches, and stops on the halt word. A Req/Ack handshake starts each
// program run and reports when it is done.
// Optional feature: define INST_COUNT_EN to add the saturating 16-bit retired-instruction
// counter and its InstCount port.
module inst_fetch_ctrl #(
    parameter int           A         = 10,
    parameter int           W         = 9,
    parameter logic [W-1:0] HALT_WORD = '1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Req,
    input  logic [A-1:0] StartAddr,
    output logic [A-1:0] InstAddress,
    input  logic [W-1:0] InstIn,
    output logic         InstValid,
    input  logic         Stall,
    input  logic         BranchEn,
    input  logic         BranchRel,
    input  logic [A-1:0] BranchTgt,
    output logic         Busy,
`ifdef INST_COUNT_EN
    output logic [15:0]  InstCount,
`endif
    output logic         Ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [A-1:0] pc_q, pc_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         ack_q, ack_d;
    logic         is_halt;
    logic         accept;

    // The halt word is recognised on live ROM data.
    // A start is accepted only from IDLE.
    always_comb begin
        is_halt = (InstIn == HALT_WORD);
        accept  = (state_q == S_IDLE) && Req;
    end

    // Next-state and next-PC selection. The RUN priority is: stall, halt, absolute branch,
    // relative branch, then sequential step.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    pc_d    = StartAddr;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (Stall) begin
                    pc_d = pc_q;
                end else if (is_halt) begin
                    // The PC stays on the halt word so it can be inspected afterwards.
                    state_d = S_HALT;
                end else if (BranchEn && !BranchRel) begin
                    pc_d = BranchTgt;
                end else if (BranchEn && BranchRel) begin
                    // A-bit add: the offset is two's complement, so wrapping covers both directions.
                    pc_d = pc_q + BranchTgt;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            S_HALT: begin
                // Req must fall before another run can start.
                if (!Req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs are decoded from the next state so they can be registered with it.
    always_comb begin
        valid_d = (state_d == S_RUN);
        busy_d  = (state_d == S_RUN);
        ack_d   = (state_d == S_HALT);
    end

    // State, PC and registered handshake outputs. Reset overrides all other inputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign InstAddress = pc_q;
    assign InstValid   = valid_q;
    assign Busy        = busy_q;
    assign Ack         = ack_q;

`ifdef INST_COUNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        retire;

    // An instruction retires on any RUN cycle that is not stalled and is not the halt word.
    // The count saturates instead of wrapping.
    always_comb begin
        retire = (state_q == S_RUN) && !Stall && !is_halt;
        cnt_d  = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (retire && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Retired-instruction counter. It is cleared by reset and by each new start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign InstCount = cnt_q;
`else
    // Without the counter, the start-acceptance decode has no consumer.
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: self-checking bench for inst_fetch_ctrl.
// The bench holds a ROM model and an abstract model of the run/halt sequence
// (integer state, integer PC arithmetic mod 1024). It uses directed scenarios
// followed by randomized traffic.
module tb_inst_fetch_ctrl;

    localparam int A = 10;
    localparam int W = 9;
    localparam int DEPTH = 1 << A;
    localparam int HALTV = (1 << W) - 1;

    logic         Clk = 1'b0;
    logic         Reset, Req, Stall, BranchEn, BranchRel;
    logic [A-1:0] StartAddr, BranchTgt, InstAddress;
    logic [W-1:0] InstIn;
    logic         InstValid, Busy, Ack;
`ifdef INST_COUNT_EN
    logic [15:0]  InstCount;
`endif

    logic [W-1:0] rom [0:DEPTH-1];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = idle, 1 = running, 2 = finished.
    int m_mode, m_pc, m_cnt;

    always #5 Clk = ~Clk;

    assign InstIn = rom[InstAddress];

    inst_fetch_ctrl #(.A(A), .W(W)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .StartAddr(StartAddr),
        .InstAddress(InstAddress), .InstIn(InstIn), .InstValid(InstValid),
        .Stall(Stall), .BranchEn(BranchEn), .BranchRel(BranchRel),
        .BranchTgt(BranchTgt), .Busy(Busy),
`ifdef INST_COUNT_EN
        .InstCount(InstCount),
`endif
        .Ack(Ack)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model and the DUT by one clock, then compare every output.
    task automatic tick();
        int ns, np, nc, off;
        ns = m_mode; np = m_pc; nc = m_cnt;
        if (Reset) begin
            ns = 0; np = 0; nc = 0;
        end else if (m_mode == 0) begin
            if (Req) begin ns = 1; np = int'(StartAddr); nc = 0; end
        end else if (m_mode == 1) begin
            if (Stall) begin
                // everything frozen
            end else if (int'(rom[m_pc]) == HALTV) begin
                ns = 2;
            end else begin
                nc = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                if (BranchEn && !BranchRel) begin
                    np = int'(BranchTgt);
                end else if (BranchEn) begin
                    off = int'(BranchTgt);
                    if (off >= DEPTH / 2) off = off - DEPTH;
                    np = ((m_pc + off) % DEPTH + DEPTH) % DEPTH;
                end else begin
                    np = (m_pc + 1) % DEPTH;
                end
            end
        end else begin
            if (!Req) ns = 0;
        end
        @(posedge Clk);
        #1;
        m_mode = ns; m_pc = np; m_cnt = nc;
        check_val("addr",  32'(InstAddress), 32'(m_pc));
        check_val("busy",  32'(Busy),        32'(m_mode == 1));
        check_val("valid", 32'(InstValid),   32'(m_mode == 1));
        check_val("ack",   32'(Ack),         32'(m_mode == 2));
`ifdef INST_COUNT_EN
        check_val("count", 32'(InstCount),   32'(m_cnt));
`endif
    endtask

    task automatic idle_inputs();
        Reset = 1'b0; Req = 1'b0; Stall = 1'b0; BranchEn = 1'b0;
        BranchRel = 1'b0; BranchTgt = '0; StartAddr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        m_mode = 0; m_pc = 0; m_cnt = 0;
        for (int i = 0; i < DEPTH; i++) rom[i] = W'(i % 64);
        idle_inputs();
        @(negedge Clk);

        // Reset state
        do_reset();
        check_val("rst_addr", 32'(InstAddress), 32'd0);
        check_val("rst_busy", 32'(Busy), 32'd0);
        check_val("rst_ack",  32'(Ack),  32'd0);

        // Scenario 1: words 0..3 execute, word 4 halts
        rom[4] = '1;
        Req = 1'b1; StartAddr = 10'd0;
        tick();
        check_val("t1_first", 32'(InstAddress), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_val("t1_seq", 32'(InstAddress), 32'(k));
        end
        tick();
        check_val("t1_ack", 32'(Ack), 32'd1);
        check_val("t1_pc",  32'(InstAddress), 32'd4);
`ifdef INST_COUNT_EN
        check_val("t1_cnt", 32'(InstCount), 32'd4);
`endif
        // Scenario 6: Req held keeps HALT, a low-high cycle restarts
        tick();
        check_val("t6_hold", 32'(Ack), 32'd1);
        Req = 1'b0;
        tick();
        check_val("t6_idle", 32'(Ack), 32'd0);
        Req = 1'b1; StartAddr = 10'd300;
        tick();
        check_val("t6_pc", 32'(InstAddress), 32'd300);
        Req = 1'b0;
        tick();
`ifdef INST_COUNT_EN
        check_val("t6_cnt", 32'(InstCount), 32'd1);
`endif
        rom[4] = 9'd4;

        // Scenario 2: absolute then relative branch
        do_reset();
        Req = 1'b1; StartAddr = 10'd5;
        tick();
        Req = 1'b0; BranchEn = 1'b1; BranchRel = 1'b0; BranchTgt = 10'd200;
        tick();
        check_val("t2_abs", 32'(InstAddress), 32'd200);
        BranchRel = 1'b1; BranchTgt = 10'h3FE;
        tick();
        check_val("t2_rel", 32'(InstAddress), 32'd198);
        BranchEn = 1'b0; BranchRel = 1'b0;

        // Scenario 3: forward wrap and backward relative wrap
        do_reset();
        Req = 1'b1; StartAddr = 10'h3FF;
        tick();
        Req = 1'b0;
        tick();
        check_val("t3_wrap", 32'(InstAddress), 32'd0);
        tick();
        BranchEn = 1'b1; BranchRel = 1'b1; BranchTgt = 10'h3FD;
        tick();
        check_val("t3_relwrap", 32'(InstAddress), 32'h3FE);
        BranchEn = 1'b0; BranchRel = 1'b0;

        // Scenario 4: stall beats halt and branch
        do_reset();
        rom[7] = '1;
        Req = 1'b1; StartAddr = 10'd7;
        tick();
        Req = 1'b0; Stall = 1'b1; BranchEn = 1'b1; BranchTgt = 10'd99;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("t4_stall_pc", 32'(InstAddress), 32'd7);
            check_val("t4_stall_ack", 32'(Ack), 32'd0);
        end
        Stall = 1'b0;
        tick();
        check_val("t4_halt", 32'(Ack), 32'd1);
        check_val("t4_pc", 32'(InstAddress), 32'd7);
        BranchEn = 1'b0;
        rom[7] = 9'd7;

        // Scenario 5: reset aborts a run
        do_reset();
        Req = 1'b1; StartAddr = 10'd50;
        tick();
        Req = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_val("t5_pc",   32'(InstAddress), 32'd0);
        check_val("t5_busy", 32'(Busy), 32'd0);
        check_val("t5_ack",  32'(Ack),  32'd0);
`ifdef INST_COUNT_EN
        check_val("t5_cnt",  32'(InstCount), 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < DEPTH; i++)
            rom[i] = ($urandom_range(0, 11) == 0) ? W'(HALTV) : W'($urandom_range(0, HALTV - 1));
        for (int c = 0; c < 4000; c++) begin
            Reset     = ($urandom_range(0, 299) == 0);
            Req       = ($urandom_range(0, 2) != 0);
            StartAddr = A'($urandom);
            Stall     = ($urandom_range(0, 3) == 0);
            BranchEn  = ($urandom_range(0, 4) == 0);
            BranchRel = $urandom_range(0, 1) == 1;
            BranchTgt = A'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
